// File: rtl/dsp_add_sched.sv
// Round-robin packer of up to two requests per cycle onto a shared two-lane adder.
// Latency: accepted in cycle t, response visible in cycle t+1; adder path is purely combinational.
// Backpressure: a held response blocks its requester until resp_ready drains it (same-cycle drain re-arms).
module dsp_add_sched #(
    parameter int width   = 24,
    parameter int num_req = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [num_req-1:0]       req_valid,
    output logic [num_req-1:0]       req_ready,
    input  logic [num_req*width-1:0] req_a,
    input  logic [num_req*width-1:0] req_b,
    output logic [num_req-1:0]       resp_valid,
    input  logic [num_req-1:0]       resp_ready,
    output logic [num_req*width-1:0] resp_data,
    output logic [width-1:0]         dsp_a,
    output logic [width-1:0]         dsp_b,
    output logic [width-1:0]         dsp_c,
    output logic [width-1:0]         dsp_d,
    input  logic [width-1:0]         dsp_y,
    input  logic [width-1:0]         dsp_z,
    output logic [31:0]              op_count
);

    localparam int pw = $clog2(num_req);

    generate
        if (width < 1 || width > 24 || num_req < 2 || num_req > 8) begin : g_param_err
            $error("dsp_add_sched: width must be 1..24 and num_req 2..8");
        end
    endgenerate

    logic [num_req-1:0] eligible;
    logic [pw-1:0]      ptr;
    logic [pw-1:0]      g0;
    logic [pw-1:0]      g1;
    logic               g0_vld;
    logic               g1_vld;

    function automatic logic [pw-1:0] next_idx(input logic [pw-1:0] i);
        return (int'(i) == num_req - 1) ? '0 : i + 1'b1;
    endfunction

    // Nothing is granted while reset is held, so the lanes idle at zero.
    always_comb begin
        eligible = '0;
        if (reset) begin
            eligible = req_valid & (~resp_valid | resp_ready);
        end
    end

    always_comb begin : grant_scan
        int idx;
        idx    = 0;
        g0     = '0;
        g1     = '0;
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        for (int k = 0; k < num_req; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (eligible[idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0     = pw'(idx);
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1     = pw'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (g0_vld) begin
            req_ready[g0] = 1'b1;
        end
        if (g1_vld) begin
            req_ready[g1] = 1'b1;
        end
    end

    assign dsp_a = g0_vld ? req_a[int'(g0)*width +: width] : '0;
    assign dsp_b = g0_vld ? req_b[int'(g0)*width +: width] : '0;
    assign dsp_c = g1_vld ? req_a[int'(g1)*width +: width] : '0;
    assign dsp_d = g1_vld ? req_b[int'(g1)*width +: width] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= '0;
            resp_data  <= '0;
            ptr        <= '0;
            op_count   <= '0;
        end else begin
            for (int i = 0; i < num_req; i++) begin
                if (g0_vld && int'(g0) == i) begin
                    resp_data[i*width +: width] <= dsp_y;
                    resp_valid[i]               <= 1'b1;
                end else if (g1_vld && int'(g1) == i) begin
                    resp_data[i*width +: width] <= dsp_z;
                    resp_valid[i]               <= 1'b1;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
            // Resume the scan just past the last requester served.
            if (g1_vld) begin
                ptr <= next_idx(g1);
            end else if (g0_vld) begin
                ptr <= next_idx(g0);
            end
            op_count <= op_count + 32'(g0_vld) + 32'(g1_vld);
        end
    end

endmodule

// File: tb/tb_dsp_add_sched.sv
// Randomized and directed bench for dsp_add_sched against a queue-based grant model.
module tb_dsp_add_sched;
    localparam int W  = 24;
    localparam int N  = 4;
    localparam int W2 = 8;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b, resp_data;
    logic [W-1:0]   dsp_a, dsp_b, dsp_c, dsp_d, dsp_y, dsp_z;
    logic [31:0]    op_count;

    logic [N-1:0]    req_valid2, req_ready2, resp_valid2, resp_ready2;
    logic [N*W2-1:0] req_a2, req_b2, resp_data2;
    logic [W2-1:0]   dsp_a2, dsp_b2, dsp_c2, dsp_d2, dsp_y2, dsp_z2;
    logic [31:0]     op_count2;

    assign dsp_y  = dsp_a + dsp_b;
    assign dsp_z  = dsp_c + dsp_d;
    assign dsp_y2 = dsp_a2 + dsp_b2;
    assign dsp_z2 = dsp_c2 + dsp_d2;

    dsp_add_sched #(.width(W), .num_req(N)) dut (
        .clock(clock), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
        .dsp_y(dsp_y), .dsp_z(dsp_z), .op_count(op_count)
    );

    dsp_add_sched #(.width(W2), .num_req(N)) dut8 (
        .clock(clock), .reset(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_a(req_a2), .req_b(req_b2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_data(resp_data2),
        .dsp_a(dsp_a2), .dsp_b(dsp_b2), .dsp_c(dsp_c2), .dsp_d(dsp_d2),
        .dsp_y(dsp_y2), .dsp_z(dsp_z2), .op_count(op_count2)
    );

    int checks = 0;
    int errors = 0;

    // Model state: held responses, scan start, operation total, and this cycle's grants.
    logic [N-1:0] rv_m;
    logic [W-1:0] rd_m [N];
    int           ptr_m;
    logic [31:0]  opc_m;
    int           g_m[$];
    logic [N-1:0] exp_mask = '0;
    logic [N-1:0] pat [3] = '{4'b0011, 4'b1100, 4'b0011};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] opa(input int i);
        return req_a[i*W +: W];
    endfunction

    function automatic logic [W-1:0] opb(input int i);
        return req_b[i*W +: W];
    endfunction

    task automatic model_reset();
        rv_m  = '0;
        ptr_m = 0;
        opc_m = '0;
        for (int i = 0; i < N; i++) rd_m[i] = '0;
    endtask

    // Walk requesters in circular order from the pointer; the first two eligible win.
    task automatic predict();
        int j;
        g_m.delete();
        exp_mask = '0;
        for (int k = 0; k < N; k++) begin
            j = (ptr_m + k) % N;
            if (g_m.size() < 2 && req_valid[j] && (!rv_m[j] || resp_ready[j])) begin
                g_m.push_back(j);
                exp_mask[j] = 1'b1;
            end
        end
    endtask

    task automatic check_now();
        logic [W-1:0] ea, eb, ec, ed;
        predict();
        ea = '0; eb = '0; ec = '0; ed = '0;
        if (g_m.size() > 0) begin ea = opa(g_m[0]); eb = opb(g_m[0]); end
        if (g_m.size() > 1) begin ec = opa(g_m[1]); ed = opb(g_m[1]); end
        chk("req_ready", 64'(req_ready), 64'(exp_mask));
        chk("dsp_a", 64'(dsp_a), 64'(ea));
        chk("dsp_b", 64'(dsp_b), 64'(eb));
        chk("dsp_c", 64'(dsp_c), 64'(ec));
        chk("dsp_d", 64'(dsp_d), 64'(ed));
        chk("resp_valid", 64'(resp_valid), 64'(rv_m));
        for (int i = 0; i < N; i++) chk("resp_data", 64'(resp_data[i*W +: W]), 64'(rd_m[i]));
        chk("op_count", 64'(op_count), 64'(opc_m));
    endtask

    task automatic advance();
        logic [W-1:0] s;
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (exp_mask[i]) begin
                s       = opa(i) + opb(i);
                rd_m[i] = s;
                rv_m[i] = 1'b1;
            end else if (resp_ready[i]) begin
                rv_m[i] = 1'b0;
            end
        end
        if (g_m.size() > 0) ptr_m = (g_m[g_m.size()-1] + 1) % N;
        opc_m = opc_m + 32'(g_m.size());
        #1;
    endtask

    task automatic tick();
        @(negedge clock);
        check_now();
        advance();
    endtask

    // Ungranted pending requests keep their operands; everything else is re-rolled.
    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !exp_mask[i])) begin
                req_valid[i]    = ($urandom_range(0, 99) < 65);
                req_a[i*W +: W] = ($urandom_range(0, 9) == 0) ? 24'hFFFFFF : W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
        end
        resp_ready = N'($urandom_range(0, 15));
    endtask

    initial begin
        logic [W-1:0] s_odd, a0, a1, a2;
        rst_n       = 1'b0;
        req_valid   = '1;
        req_a       = '1;
        req_b       = '1;
        resp_ready  = '0;
        req_valid2  = '0;
        req_a2      = '0;
        req_b2      = '0;
        resp_ready2 = '0;
        model_reset();

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_dsp_a", 64'(dsp_a), 64'h0);
        chk("rst_dsp_c", 64'(dsp_c), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_op_count", 64'(op_count), 64'h0);

        req_valid = '0;
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Idle after reset, plus the 8-bit wrap case on the narrow instance.
        req_valid2 = 4'b0011;
        req_a2     = {8'h00, 8'h00, 8'h80, 8'hFF};
        req_b2     = {8'h00, 8'h00, 8'h80, 8'h02};
        @(negedge clock);
        check_now();
        chk("idle_req_ready", 64'(req_ready), 64'h0);
        chk("idle_op_count", 64'(op_count), 64'h0);
        chk("w8_req_ready", 64'(req_ready2), 64'h3);
        chk("w8_dsp_a", 64'(dsp_a2), 64'hFF);
        chk("w8_dsp_c", 64'(dsp_c2), 64'h80);
        advance();
        req_valid2 = '0;
        chk("w8_resp_valid", 64'(resp_valid2), 64'h3);
        chk("w8_lane0_sum", 64'(resp_data2[7:0]), 64'h01);
        chk("w8_lane1_sum", 64'(resp_data2[15:8]), 64'h00);
        chk("w8_untouched", 64'(resp_data2[31:16]), 64'h0);

        // All four requesting with drains: pairs alternate {0,1},{2,3},{0,1}.
        req_valid  = '1;
        resp_ready = '1;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = W'($urandom);
                req_b[i*W +: W] = W'($urandom);
            end
            s_odd = opa(pat[c][0] ? 1 : 3) + opb(pat[c][0] ? 1 : 3);
            @(negedge clock);
            check_now();
            chk("pair_grant", 64'(req_ready), 64'(pat[c]));
            chk("pair_op_count", 64'(op_count), 64'(2 * c));
            advance();
            chk("lane1_sum", 64'(resp_data[(pat[c][0] ? 1 : 3)*W +: W]), 64'(s_odd));
        end

        // Single requester 2 with 5 + 7.
        req_valid       = 4'b0100;
        resp_ready      = '0;
        req_a[2*W +: W] = 24'd5;
        req_b[2*W +: W] = 24'd7;
        @(negedge clock);
        check_now();
        chk("single_grant", 64'(req_ready), 64'h4);
        chk("single_dsp_a", 64'(dsp_a), 64'd5);
        chk("single_dsp_b", 64'(dsp_b), 64'd7);
        chk("single_dsp_c", 64'(dsp_c), 64'd0);
        chk("single_dsp_d", 64'(dsp_d), 64'd0);
        advance();
        req_valid = '0;
        @(negedge clock);
        check_now();
        chk("single_resp_valid", 64'(resp_valid[2]), 64'h1);
        chk("single_resp_data", 64'(resp_data[2*W +: W]), 64'd12);
        chk("single_op_count", 64'(op_count), 64'd7);
        advance();

        // Requester 1 holds an undrained response; only requester 0 may go.
        req_valid  = 4'b0011;
        resp_ready = 4'b0001;
        a0 = W'($urandom);
        a1 = W'($urandom);
        req_a[0 +: W] = a0;
        req_a[W +: W] = a1;
        @(negedge clock);
        check_now();
        chk("bp_grant", 64'(req_ready), 64'h1);
        chk("bp_dsp_a", 64'(dsp_a), 64'(a0));
        chk("bp_dsp_c", 64'(dsp_c), 64'h0);
        advance();
        resp_ready = 4'b0011;
        @(negedge clock);
        check_now();
        chk("bp_release_grant", 64'(req_ready), 64'h3);
        chk("bp_release_dsp_a", 64'(dsp_a), 64'(a1));
        chk("bp_release_dsp_c", 64'(dsp_c), 64'(a0));
        advance();

        repeat (400) begin
            rand_inputs();
            tick();
        end

        // Fill every response slot, then pull reset between clock edges.
        req_valid  = '1;
        resp_ready = '0;
        repeat (3) tick();
        chk("prefill_resp_valid", 64'(resp_valid), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_resp_valid", 64'(resp_valid), 64'h0);
        chk("async_req_ready", 64'(req_ready), 64'h0);
        chk("async_dsp_a", 64'(dsp_a), 64'h0);
        chk("async_op_count", 64'(op_count), 64'h0);
        model_reset();
        @(posedge clock);
        #1;
        chk("held_resp_valid", 64'(resp_valid), 64'h0);
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        a1 = W'($urandom);
        a2 = W'($urandom);
        req_a[W +: W]   = a1;
        req_a[2*W +: W] = a2;
        @(negedge clock);
        check_now();
        chk("post_rst_grant", 64'(req_ready), 64'h6);
        chk("post_rst_dsp_a", 64'(dsp_a), 64'(a1));
        chk("post_rst_dsp_c", 64'(dsp_c), 64'(a2));
        advance();
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
